// File: rtl/vram_arb_pkg.sv
// Shared types for the character VRAM arbiter.
// Holds CPU FSM states, read-return owner tags and latency limits.
`timescale 1ns/1ps
package vram_arb_pkg;

  localparam int RAM_LAT_MIN = 1;
  localparam int RAM_LAT_MAX = 2;

  typedef enum logic [1:0] {
    C_IDLE,
    C_WAIT,
    C_FLIGHT,
    C_HOLD
  } cpu_state_t;

  typedef enum logic [1:0] {
    NONE,
    CPU,
    VID
  } owner_t;

  typedef struct packed {
    owner_t owner;
    logic   snow;
  } rd_tag_t;

  function automatic int clamp_lat(input int lat);
    if (lat > RAM_LAT_MAX) return RAM_LAT_MAX;
    if (lat < RAM_LAT_MIN) return RAM_LAT_MIN;
    return lat;
  endfunction

endpackage

// File: rtl/vram_arb_rdpipe.sv
// Owner/snow tag delay line, aligned with the RAM read data.
// Reset drops every in-flight tag so no stale completion escapes.
`timescale 1ns/1ps
module vram_arb_rdpipe
  import vram_arb_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic    clock,
  input  logic    reset_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t pipe_q [LAT];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= '{owner: NONE, snow: 1'b0};
      end
    end else begin
      pipe_q[0] <= tag_in;
      for (int i = 1; i < LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_out = pipe_q[LAT-1];

endmodule

// File: rtl/vram_arbiter.sv
// Z80 / video scan-out arbiter in front of a single-port VRAM.
// VRAM_SNOW_EN: CPU always wins and colliding fetches show snow.
`timescale 1ns/1ps
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int RAM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_valid,
  output logic              vid_snow,
  output logic              vid_overrun,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int LAT = clamp_lat(RAM_LAT);

  cpu_state_t        state_q;
  cpu_state_t        state_d;
  logic              ack_d;
  logic              cpu_pend;
  logic              vid_want;
  logic              gnt_cpu;
  logic              gnt_vid;
  logic              cpu_done;
  logic              vid_done;
  logic              snow_wr;
  logic              vpend_q;
  logic [ADDR_W-1:0] vaddr_q;
  logic [ADDR_W-1:0] vid_a;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] snow_q;
  rd_tag_t           tag_in;
  rd_tag_t           tag_out;

  assign cpu_pend = reset_n & cpu_req
                  & ((state_q == C_IDLE)
                  |  (state_q == C_WAIT));
  assign vid_want = reset_n & (vid_req | vpend_q);
  // A fresh fetch replaces whatever is pending
  assign vid_a = vid_req ? vid_addr : vaddr_q;

`ifdef VRAM_SNOW_EN
  assign gnt_cpu = cpu_pend;
  assign gnt_vid = vid_want;
  assign cpu_wait_n = !(cpu_req
                    & ((state_q == C_FLIGHT)
                    |  ((state_q != C_HOLD) & !cpu_we)));
`else
  logic lost_q;

  assign gnt_vid = vid_want & !(lost_q & cpu_pend);
  assign gnt_cpu = cpu_pend & !gnt_vid;
  assign cpu_wait_n = !(cpu_req & (state_q != C_HOLD));

  // CPU owns the slot right after it lost one
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) lost_q <= 1'b0;
    else          lost_q <= cpu_pend & !gnt_cpu;
  end
`endif

  assign ram_we   = gnt_cpu & cpu_we;
  assign ram_addr = gnt_cpu ? cpu_addr
                  : gnt_vid ? vid_a
                  : addr_q;
  assign ram_din  = gnt_cpu ? cpu_wdata : din_q;

  always_comb begin
    tag_in = '{owner: NONE, snow: 1'b0};
    if (gnt_cpu && !cpu_we) tag_in.owner = CPU;
    else if (gnt_vid)       tag_in.owner = VID;
`ifdef VRAM_SNOW_EN
    tag_in.snow = gnt_cpu & gnt_vid;
`endif
  end

  vram_arb_rdpipe #(
    .LAT (LAT)
  ) u_rdpipe (
    .clock   (clock),
    .reset_n (reset_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign cpu_done = tag_out.owner == CPU;
  assign vid_done = (tag_out.owner == VID)
                  | (cpu_done & tag_out.snow);
  assign snow_wr  = (tag_out.owner == VID)
                  & tag_out.snow;

`ifdef VRAM_SNOW_EN
  logic [DATA_W-1:0] snow_d [LAT];

  // Written byte rides along so the beam shows it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LAT; i++) snow_d[i] <= '0;
    end else begin
      snow_d[0] <= cpu_wdata;
      for (int i = 1; i < LAT; i++) snow_d[i] <= snow_d[i-1];
    end
  end

  assign snow_q = snow_d[LAT-1];
`else
  assign snow_q = ram_q;
`endif

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    unique case (state_q)
      C_IDLE, C_WAIT: begin
        if (!cpu_req) begin
          state_d = C_IDLE;
        end else if (gnt_cpu) begin
          if (cpu_we) begin
            state_d = C_HOLD;
            ack_d   = 1'b1;
          end else begin
            state_d = C_FLIGHT;
          end
        end else begin
          state_d = C_WAIT;
        end
      end
      C_FLIGHT: begin
        if (cpu_done) begin
          state_d = C_HOLD;
          ack_d   = 1'b1;
        end
      end
      C_HOLD: begin
        if (!cpu_req) state_d = C_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= C_IDLE;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
      vid_valid   <= 1'b0;
      vid_rdata   <= '0;
      vid_snow    <= 1'b0;
      vid_overrun <= 1'b0;
      vpend_q     <= 1'b0;
      vaddr_q     <= '0;
      addr_q      <= '0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      cpu_ack     <= ack_d;
      if (cpu_done) cpu_rdata <= ram_q;
      vid_valid   <= vid_done;
      vid_snow    <= vid_done & tag_out.snow;
      if (vid_done) begin
        vid_rdata <= snow_wr ? snow_q : ram_q;
      end
      vid_overrun <= vid_overrun | (vid_req & vpend_q);
      vpend_q     <= vid_want & !gnt_vid;
      if (vid_want && !gnt_vid) vaddr_q <= vid_a;
      addr_q      <= ram_addr;
      din_q       <= ram_din;
    end
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port arbiter sharing the 1K character VRAM between the Z80 bus, via glue chip-select, and the video scan-out fetch. Sits between the CPU/glue logic and the video controller, in front of one single-port synchronous RAM. Stretches CPU accesses with wait states on collision, and guarantees every video fetch completes within one extra cycle.

## Interface
Parameters:
- ADDR_W, 10, VRAM address width
- DATA_W, 8, data width
- RAM_LAT, 1, RAM read latency in cycles from issue to valid `ram_q`; legal values are 1 and 2

Ports:
- clock  in  1  single clock for CPU, video and RAM sides
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  level request: VRAM chip-select & MREQ & (RD|WR); held until `cpu_ack`
- cpu_we  in  1  1 = write, 0 = read; stable while `cpu_req` is high
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  registered read data; held until the next CPU read completes
- cpu_ack  out  1  one-cycle completion pulse
- cpu_wait_n  out  1  to the CPU WAIT_n input; low while an access is pending
- vid_req  in  1  one-cycle fetch pulse
- vid_addr  in  ADDR_W  fetch address; valid with `vid_req`
- vid_rdata  out  DATA_W  fetched character
- vid_valid  out  1  one-cycle pulse; `vid_rdata` is valid in that cycle
- vid_snow  out  1  collision marker; always 0 unless VRAM_SNOW_EN is defined
- vid_overrun  out  1  sticky error flag; cleared only by reset
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_we  out  1  RAM write enable
- ram_q  in  DATA_W  RAM read data

## Operation
- At most one RAM access is issued per cycle.
- `ram_addr`, `ram_din` and `ram_we` are combinational from the current cycle's grant. With no grant, `ram_we` = 0 and the address holds its last value.
- The video request is latched into a one-deep `vid_pend` register, holding the request and its address.
- CPU state machine:
  - C_IDLE: on `cpu_req` → C_WAIT.
  - C_WAIT: on grant, a write → C_HOLD with `cpu_ack`; a read → C_FLIGHT.
  - C_FLIGHT: after RAM_LAT cycles, capture `cpu_rdata` and pulse `cpu_ack` → C_HOLD.
  - C_HOLD: waits for `cpu_req` = 0 → C_IDLE. A request held high after ack is never re-serviced.
- Grant priority, without macro:
  - Video (`vid_pend` or `vid_req`) wins, except in the cycle directly after a cycle where the CPU lost. That cycle belongs to the CPU.
  - Result: CPU waits at most 1 collision cycle, and video is deferred at most 1 cycle.
- `vid_req` arriving while `vid_pend` is still unserved sets `vid_overrun`. The new request replaces the pending one.
- `cpu_wait_n` = !(`cpu_req` & state ∈ {C_IDLE, C_WAIT, C_FLIGHT}). It is combinational and returns high in the `cpu_ack` cycle.
- Owner tags travel alongside RAM_LAT, so returning `ram_q` is routed to the CPU or to video.

## Timing
- Reset values: `cpu_rdata` = 0, `vid_rdata` = 0, `cpu_ack` = 0, `vid_valid` = 0, `vid_snow` = 0, `vid_overrun` = 0, `ram_we` = 0, `ram_addr` = 0, `ram_din` = 0.
- On reset: CPU state → C_IDLE, `vid_pend` cleared, in-flight reads discarded with no ack or valid.
- Uncontested write: issued in cycle t, `cpu_ack` at t+1.
- Uncontested read: issued in cycle t, `cpu_ack` and `cpu_rdata` at t+RAM_LAT+1.
- Uncontested video fetch: `vid_req` at t, `vid_valid` at t+RAM_LAT+1. A deferred fetch arrives +1 cycle later.
- Simultaneous CPU write and video fetch to the same address: video is served first and returns the old data.
- `cpu_req` dropped mid-C_WAIT: the access is abandoned and no ack is given. `cpu_req` dropped in C_FLIGHT: the read completes and `cpu_ack` still pulses.

## Configuration
- VRAM_SNOW_EN defined:
  - CPU has absolute priority and `cpu_wait_n` stays high through collisions; only RAM latency stretches reads.
  - A colliding video fetch is not deferred; `vid_valid` keeps its nominal latency.
  - `vid_rdata` = `cpu_wdata` on a write collision, or the CPU read data on a read collision, with `vid_snow` = 1.
  - This reproduces the original Model I display snow.
- VRAM_SNOW_EN undefined: the fair video-priority scheme above applies, and `vid_snow` is tied to 0.

## Structure
- Package `vram_arb_pkg`:
  - CPU state enum (C_IDLE, C_WAIT, C_FLIGHT, C_HOLD)
  - owner tag enum (NONE, CPU, VID)
  - localparams for the legal RAM_LAT range
- One sub-module, `vram_arb_rdpipe`: a RAM_LAT-deep shift register carrying owner tag and snow flag, aligned with `ram_q`.

## Test plan
- Reset with RAM_LAT=1: all outputs read 0. CPU read of 0x155 containing 0x41 → `cpu_ack` at cycle 2, `cpu_rdata` = 0x41, `cpu_wait_n` low for cycles 0–1.
- CPU write 0x3C0←0x2A and `vid_req` 0x3C0, both at cycle 0 → `vid_rdata` = old value 0x20 at cycle 2. Write issued at cycle 1, `cpu_ack` at cycle 2. A following read returns 0x2A.
- `vid_req` every cycle for 8 cycles with `cpu_req` held → CPU served within 2 cycles, one video fetch deferred, `vid_overrun` = 1.
- Assert reset_n low while a RAM_LAT=2 read is in flight → no `cpu_ack` and no `vid_valid`; state returns to C_IDLE.
- VRAM_SNOW_EN: CPU write 0x7F and `vid_req` in the same cycle → `vid_valid` at nominal latency with `vid_rdata` = 0x7F, `vid_snow` = 1, and `cpu_wait_n` never low.
